disp_7seg_mux: RTL and testbench

DISP_7SEG_MUX -- requirements
Module: disp_7seg_mux

---
 rtl/disp_7seg_pkg.sv | 24 ++
 rtl/seg7_decode.sv | 34 +++
 rtl/disp_7seg_mux.sv | 132 +++++++++++++
 tb/tb_disp_7seg_mux.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/disp_7seg_pkg.sv
// Segment patterns shared by the display blocks. Bit order is a..g, MSB to LSB.
// Native encoding is active-low: a 0 bit lights its segment.
package disp_7seg_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b1100000;
    localparam logic [6:0] SEG_C    = 7'b0110001;
    localparam logic [6:0] SEG_D    = 7'b1000010;
    localparam logic [6:0] SEG_E    = 7'b0110000;
    localparam logic [6:0] SEG_F    = 7'b0111000;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to native 7-segment pattern; hex_mode=0 shows a dash for 10..15.
// Latency: combinational. Backpressure: none.
// Flow: pure function of its inputs, no handshake.
module seg7_decode
    import disp_7seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = hex_mode ? SEG_A : SEG_DASH;
            4'hB: pattern = hex_mode ? SEG_B : SEG_DASH;
            4'hC: pattern = hex_mode ? SEG_C : SEG_DASH;
            4'hD: pattern = hex_mode ? SEG_D : SEG_DASH;
            4'hE: pattern = hex_mode ? SEG_E : SEG_DASH;
            4'hF: pattern = hex_mode ? SEG_F : SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_7seg_mux.sv
// Multiplexed 7-seg driver with PWM brightness; DISP_7SEG_MUX_LZB_EN blanks leading zeros.
// Latency: outputs registered one cycle after counter state. Backpressure: en=0 blanks and freezes.
// val_in is sampled into a shadow once per frame, so a frame never shows torn data.
module disp_7seg_mux
    import disp_7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_DIGITS*4-1:0] val_in,
    input  logic                    hex_mode,
    input  logic [2:0]              bright,
    input  logic                    seg_inv,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q;
    logic [2:0]              phase_q;
    logic [DW-1:0]           dig_q;
    logic [NUM_DIGITS*4-1:0] shadow_q;
    logic                    loaded_q;
    logic [6:0]              seg_nat_q;
    logic [NUM_DIGITS-1:0]   dig_sel_q;
    logic                    frame_tick_q;

    logic                    run;
    logic                    presc_wrap;
    logic                    phase_wrap;
    logic                    frame_wrap;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [6:0]              dec_pat;

    // The first cycle after reset only loads the shadow, so digit 0 never shows stale data.
    assign run        = en & loaded_q;
    assign presc_wrap = (presc_q == PRESC_LAST);
    assign phase_wrap = presc_wrap && (phase_q == 3'd7);
    assign frame_wrap = run && phase_wrap && (dig_q == DIG_LAST);

`ifdef DISP_7SEG_MUX_LZB_EN
    logic zero_run;

    // Blank each zero nibble in the unbroken run from the top digit; digit 0 always shows.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (shadow_q[i*4 +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q == DW'(i)) begin
                cur_nib   = shadow_q[i*4 +: 4];
                cur_blank = lz_mask[i];
            end
        end
    end

    seg7_decode u_decode (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .pattern  (dec_pat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            phase_q  <= 3'd0;
            dig_q    <= '0;
            shadow_q <= '0;
            loaded_q <= 1'b0;
        end else begin
            if (!loaded_q) begin
                loaded_q <= 1'b1;
                shadow_q <= val_in;
            end else if (frame_wrap) begin
                shadow_q <= val_in;
            end
            if (run) begin
                presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
                if (presc_wrap) begin
                    phase_q <= phase_q + 3'd1;
                end
                if (phase_wrap) begin
                    dig_q <= (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_nat_q    <= SEG_OFF;
            dig_sel_q    <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_wrap;
            if (run) begin
                dig_sel_q <= NUM_DIGITS'(1) << dig_q;
                seg_nat_q <= ((phase_q <= bright) && !cur_blank) ? dec_pat : SEG_OFF;
            end else begin
                dig_sel_q <= '0;
                seg_nat_q <= SEG_OFF;
            end
        end
    end

    // Polarity is applied after the register so the reset value tracks seg_inv.
    assign seg_out    = seg_nat_q ^ {7{seg_inv}};
    assign dig_sel    = dig_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_7seg_mux.sv
// Directed bench for disp_7seg_mux with NUM_DIGITS=4, PRESCALE=2 (16 cycles per digit, 64 per frame).
// Expected patterns are hand-written constants; cyc tracks the counter state being displayed.
module tb_disp_7seg_mux;

    localparam logic [6:0] P0   = 7'b0000001;
    localparam logic [6:0] P1   = 7'b1001111;
    localparam logic [6:0] P2   = 7'b0010010;
    localparam logic [6:0] P3   = 7'b0000110;
    localparam logic [6:0] P4   = 7'b1001100;
    localparam logic [6:0] PA   = 7'b0001000;
    localparam logic [6:0] PF   = 7'b0111000;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] OFF  = 7'b1111111;
`ifdef DISP_7SEG_MUX_LZB_EN
    localparam logic [6:0] LZ   = 7'b1111111;
`else
    localparam logic [6:0] LZ   = 7'b0000001;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] val_in;
    logic        hex_mode;
    logic [2:0]  bright;
    logic        seg_inv;
    logic [6:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    disp_7seg_mux #(.NUM_DIGITS(4), .PRESCALE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .val_in     (val_in),
        .hex_mode   (hex_mode),
        .bright     (bright),
        .seg_inv    (seg_inv),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each iteration samples the outputs produced from counter state cyc.
    task automatic scan(input int n, input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2, input logic [6:0] d3,
                        input int brt, input logic inv, input string tag);
        int d;
        int ph;
        logic [6:0] pat;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            d   = (cyc / 16) % 4;
            ph  = (cyc % 16) / 2;
            pat = (d == 0) ? d0 : (d == 1) ? d1 : (d == 2) ? d2 : d3;
            if (ph > brt) pat = OFF;
            pat = pat ^ {7{inv}};
            chk($sformatf("%s c%0d dig_sel", tag, cyc), 32'(dig_sel), 32'(4'b0001 << d));
            chk($sformatf("%s c%0d seg_out", tag, cyc), 32'(seg_out), 32'(pat));
            chk($sformatf("%s c%0d frame_tick", tag, cyc), 32'(frame_tick),
                32'((cyc % 64) == 63));
            cyc++;
        end
    endtask

    task automatic do_reset(input logic [15:0] v);
        rst    = 1'b1;
        val_in = v;
        @(negedge clk);
        chk("rst dig_sel", 32'(dig_sel), 32'h0);
        chk("rst seg_out", 32'(seg_out), 32'(OFF ^ {7{seg_inv}}));
        chk("rst frame_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("load cycle dig_sel", 32'(dig_sel), 32'h0);
        cyc = 0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        hex_mode = 1'b0;
        bright   = 3'd7;
        seg_inv  = 1'b1;
        val_in   = 16'h1234;
        @(negedge clk);
        chk("rst inverted seg_out", 32'(seg_out), 32'h00);
        seg_inv = 1'b0;
        #1;
        chk("rst native seg_out", 32'(seg_out), 32'h7f);

        do_reset(16'h1234);
        scan(128, P4, P3, P2, P1, 7, 1'b0, "bcd1234");

        bright = 3'd1;
        scan(64, P4, P3, P2, P1, 1, 1'b0, "bright1");
        bright = 3'd7;

        seg_inv = 1'b1;
        scan(16, P4, P3, P2, P1, 7, 1'b1, "inv");
        seg_inv = 1'b0;

        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("en0 %0d dig_sel", k), 32'(dig_sel), 32'h0);
            chk($sformatf("en0 %0d seg_out", k), 32'(seg_out), 32'h7f);
            chk($sformatf("en0 %0d frame_tick", k), 32'(frame_tick), 32'h0);
        end
        en = 1'b1;
        scan(88, P4, P3, P2, P1, 7, 1'b0, "resume");

        // cyc%64 is now 40: digit 2 is on screen
        rst = 1'b1;
        #1;
        chk("midrst dig_sel", 32'(dig_sel), 32'h0);
        chk("midrst seg_out", 32'(seg_out), 32'h7f);
        chk("midrst frame_tick", 32'(frame_tick), 32'h0);
        do_reset(16'h1234);
        scan(32, P4, P3, P2, P1, 7, 1'b0, "after_rst");

        do_reset(16'h1111);
        scan(20, P1, P1, P1, P1, 7, 1'b0, "shadow_old");
        val_in = 16'h2222;
        scan(44, P1, P1, P1, P1, 7, 1'b0, "shadow_hold");
        scan(64, P2, P2, P2, P2, 7, 1'b0, "shadow_new");

        hex_mode = 1'b1;
        do_reset(16'h00AF);
        scan(64, PF, PA, LZ, LZ, 7, 1'b0, "hex00AF");
        hex_mode = 1'b0;
        scan(64, DASH, DASH, LZ, LZ, 7, 1'b0, "bcd00AF");

        do_reset(16'h0040);
        scan(64, P0, P4, LZ, LZ, 7, 1'b0, "lz0040");
        do_reset(16'h0000);
        scan(64, P0, LZ, LZ, LZ, 7, 1'b0, "lz0000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
